// File: rtl/risc_spm_mem_pkg.sv
// Shared defaults and state type for the RISC_SPM memory unit.
package risc_spm_mem_pkg;

  localparam int unsigned DefDw = 8;
  localparam int unsigned DefAw = 8;
  localparam int unsigned ViolW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRelease,
    StRun
  } mem_state_e;

endpackage

// File: rtl/risc_spm_mem_array.sv
// DEPTH x DW word storage: one synchronous write port, one combinational read port.
module risc_spm_mem_array #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned Depth = 2 ** AW;

  logic [DW-1:0] mem [Depth];

  // No reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/risc_spm_mem_unit.sv
// RISC_SPM memory responder with a word-stream program loader that holds the CPU in reset.
// Optional write protection of the low region is enabled by defining WRITE_PROTECT_EN.
module risc_spm_mem_unit
  import risc_spm_mem_pkg::*;
#(
  parameter int unsigned DW         = DefDw,
  parameter int unsigned AW         = DefAw,
  parameter int unsigned PROT_LIMIT = 'h80
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    address,
  input  logic [DW-1:0]    data_in,
  input  logic             write,
  output logic [DW-1:0]    data_out,
  input  logic             load_start,
  input  logic             ld_valid,
  input  logic [DW-1:0]    ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  output logic [AW:0]      load_len,
  output logic             cpu_rst_n,
  output logic             prot_viol,
  output logic [ViolW-1:0] viol_cnt
);

  localparam logic [AW-1:0] ProtLim = AW'(PROT_LIMIT);

  mem_state_e    state_q, state_d;
  logic [AW-1:0] ld_ptr_q, ld_ptr_d;
  logic [AW:0]   load_len_q, load_len_d;
  logic          cpu_rst_n_q;
  logic          ld_xfer, cpu_try, cpu_we, mem_we, addr_below;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  always_comb begin
    state_d    = state_q;
    ld_ptr_d   = ld_ptr_q;
    load_len_d = load_len_q;
    ld_xfer    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_start) begin
          state_d  = StLoad;
          ld_ptr_d = '0;
        end
      end
      StLoad: begin
        ld_xfer = ld_valid;
        if (ld_valid) begin
          // Last word or top of memory ends the load; pointer never wraps.
          if (ld_last || (ld_ptr_q == '1)) begin
            state_d    = StRelease;
            load_len_d = {1'b0, ld_ptr_q} + 1'b1;
          end else begin
            ld_ptr_d = ld_ptr_q + 1'b1;
          end
        end
      end
      StRelease: state_d = StRun;
      StRun: begin
        if (load_start) begin
          state_d  = StLoad;
          ld_ptr_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ld_ptr_q    <= '0;
      load_len_q  <= '0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_ptr_q    <= ld_ptr_d;
      load_len_q  <= load_len_d;
      cpu_rst_n_q <= (state_d == StRun);
    end
  end

  // A write in the same cycle as a reload request is dropped with the CPU going into reset.
  assign cpu_try    = (state_q == StRun) && write && !load_start;
  assign addr_below = (address < ProtLim);

`ifdef WRITE_PROTECT_EN
  logic             viol_d, prot_viol_q;
  logic [ViolW-1:0] viol_cnt_q;

  assign viol_d = cpu_try && addr_below;
  assign cpu_we = cpu_try && !addr_below;

  always_ff @(posedge clk) begin
    if (rst) begin
      prot_viol_q <= 1'b0;
      viol_cnt_q  <= '0;
    end else begin
      prot_viol_q <= viol_d;
      if (viol_d && (viol_cnt_q != '1)) begin
        viol_cnt_q <= viol_cnt_q + 1'b1;
      end
    end
  end

  assign prot_viol = prot_viol_q;
  assign viol_cnt  = viol_cnt_q;
`else
  logic unused_prot;

  assign unused_prot = addr_below;
  assign cpu_we      = cpu_try;
  assign prot_viol   = 1'b0;
  assign viol_cnt    = '0;
`endif

  // Loader and CPU live in disjoint states, so the mux never sees both.
  assign mem_we    = ld_xfer | cpu_we;
  assign mem_waddr = ld_xfer ? ld_ptr_q : address;
  assign mem_wdata = ld_xfer ? ld_data : data_in;

  risc_spm_mem_array #(
    .DW(DW),
    .AW(AW)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(mem_wdata),
    .raddr(address),
    .rdata(data_out)
  );

  assign ld_ready  = (state_q == StLoad);
  assign load_len  = load_len_q;
  assign cpu_rst_n = cpu_rst_n_q;

endmodule

// File: tb/tb_risc_spm_mem_unit.sv
// Directed bench for risc_spm_mem_unit with a transaction-level model checked every cycle.
module tb_risc_spm_mem_unit;

  logic       clk = 1'b0;
  logic       rst, write, load_start, ld_valid, ld_last;
  logic [7:0] address, data_in, ld_data;
  logic [7:0] data_out, viol_cnt;
  logic [8:0] load_len;
  logic       ld_ready, cpu_rst_n, prot_viol;

  always #5 clk = ~clk;

  risc_spm_mem_unit dut (
    .clk       (clk),
    .rst       (rst),
    .address   (address),
    .data_in   (data_in),
    .write     (write),
    .data_out  (data_out),
    .load_start(load_start),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .load_len  (load_len),
    .cpu_rst_n (cpu_rst_n),
    .prot_viol (prot_viol),
    .viol_cnt  (viol_cnt)
  );

`ifdef WRITE_PROTECT_EN
  localparam bit Prot = 1'b1;
`else
  localparam bit Prot = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Model: phase 0 idle, 1 loading, 2 one-cycle release, 3 running.
  int       m_phase = 0;
  int       m_ptr = 0;
  int       m_len = 0;
  int       m_vc = 0;
  bit       m_pv = 0;
  bit [7:0] m_mem [256];
  bit       m_known [256];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    m_pv = 1'b0;
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_len = 0; m_vc = 0;
    end else if (m_phase == 0) begin
      if (load_start) begin m_phase = 1; m_ptr = 0; end
    end else if (m_phase == 1) begin
      if (ld_valid) begin
        m_mem[m_ptr] = ld_data;
        m_known[m_ptr] = 1'b1;
        if (ld_last || m_ptr == 255) begin m_len = m_ptr + 1; m_phase = 2; end
        else m_ptr++;
      end
    end else if (m_phase == 2) begin
      m_phase = 3;
    end else begin
      if (load_start) begin
        m_phase = 1; m_ptr = 0;
      end else if (write) begin
        if (Prot && address < 8'h80) begin
          m_pv = 1'b1;
          if (m_vc < 255) m_vc++;
        end else begin
          m_mem[address] = data_in;
          m_known[address] = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ld_ready", int'(ld_ready), int'(m_phase == 1));
      chk("cpu_rst_n", int'(cpu_rst_n), int'(m_phase == 3));
      chk("load_len", int'(load_len), m_len);
      chk("prot_viol", int'(prot_viol), int'(m_pv));
      chk("viol_cnt", int'(viol_cnt), m_vc);
      if (m_known[address]) chk("data_out", int'(data_out), int'(m_mem[address]));
    end
  end

  task automatic rd(input string name, input logic [7:0] a, input int exp);
    address = a;
    #1;
    chk(name, int'(data_out), exp);
  endtask

  initial begin
    rst = 1'b1; write = 1'b0; load_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    address = 8'h00; data_in = 8'h00; ld_data = 8'h00;
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    tick(); tick();
    chk_en = 1'b1;
    chk("rst cpu_rst_n", int'(cpu_rst_n), 0);
    chk("rst ld_ready", int'(ld_ready), 0);
    chk("rst load_len", int'(load_len), 0);
    rst = 1'b0;
    tick();

    // 3-word load ending on ld_last
    load_start = 1'b1; tick(); load_start = 1'b0;
    chk("load ld_ready", int'(ld_ready), 1);
    ld_valid = 1'b1; ld_data = 8'h11; tick();
    ld_data = 8'h22; tick();
    ld_data = 8'h33; ld_last = 1'b1; tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("release cpu_rst_n", int'(cpu_rst_n), 0);
    chk("load_len 3", int'(load_len), 3);
    tick();
    chk("run cpu_rst_n", int'(cpu_rst_n), 1);
    rd("mem0", 8'h00, 'h11);
    rd("mem1", 8'h01, 'h22);
    rd("mem2", 8'h02, 'h33);

    // CPU write in RUN
    address = 8'hA0; data_in = 8'h5A; write = 1'b1; tick(); write = 1'b0;
    chk("wr A0", int'(data_out), 'h5A);

    // Reload from RUN with a same-cycle CPU write that must be dropped
    data_in = 8'h77; write = 1'b1; load_start = 1'b1; tick();
    write = 1'b0; load_start = 1'b0;
    chk("reload cpu_rst_n", int'(cpu_rst_n), 0);
    chk("dropped wr A0", int'(data_out), 'h5A);
    ld_valid = 1'b1; ld_data = 8'h44; tick();
    ld_valid = 1'b0; ld_data = 8'hEE;
    for (int i = 0; i < 4; i++) tick();
    ld_valid = 1'b1; ld_data = 8'h55; ld_last = 1'b1; tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("gap load_len", int'(load_len), 2);
    rd("gap mem0", 8'h00, 'h44);
    rd("gap mem1", 8'h01, 'h55);
    rd("gap mem2 kept", 8'h02, 'h33);
    tick();

    // Full-depth load without ld_last
    load_start = 1'b1; tick(); load_start = 1'b0;
    ld_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ld_data = 8'(i) ^ 8'h3C;
      tick();
    end
    ld_valid = 1'b0;
    chk("full load_len", int'(load_len), 256);
    chk("full ld_ready", int'(ld_ready), 0);
    rd("full mem FF", 8'hFF, 'hC3);
    tick();
    chk("full run", int'(cpu_rst_n), 1);

    // Write below the protection limit
    address = 8'h10; data_in = 8'h99; write = 1'b1; tick(); write = 1'b0;
    if (Prot) begin
      chk("prot mem", int'(data_out), 'h2C);
      chk("prot pulse", int'(prot_viol), 1);
      tick();
      chk("prot pulse end", int'(prot_viol), 0);
      chk("prot cnt", int'(viol_cnt), 1);
    end else begin
      chk("unprot mem", int'(data_out), 'h99);
      chk("unprot cnt", int'(viol_cnt), 0);
      tick();
    end

    // Reset mid-RUN keeps memory, clears load_len
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst2 load_len", int'(load_len), 0);
    chk("rst2 cpu_rst_n", int'(cpu_rst_n), 0);
    rd("rst2 mem kept", 8'hA0, int'(8'hA0 ^ 8'h3C));
    tick(); tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
